mult_fu_pipe: RTL
=================

Name: mult_fu_pipe

Overview:
- Pipelined integer multiply functional unit, directly downstream of the issue stage.
- Accepts one MULT_PACKET per cycle from issue and computes RV32M MUL/MULH/MULHSU/MULHU over NUM_STAGES pipeline stages.
- Requests the CDB one cycle before its result is ready, then broadcasts the result with its destination physical register tag.
- Backpressure to issue is via mult_free; the pipeline stalls and compresses bubbles when the CDB grant is withheld.

Parameters:
- NUM_STAGES, 4, number of compute stages; legal values 2, 4, 8; each stage consumes 64/NUM_STAGES multiplier bits.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mult_packet  in  MULT_PACKET  issued op: valid, func (MULT_FUNC), rs1_value, rs2_value (DATA), dest_reg_idx (PHYS_REG_IDX)
- squash  in  1  mispredict flush; kills all in-flight ops
- mult_cdb_gnt  in  1  CDB grant; valid only in a cycle where mult_cdb_req=1
- mult_free  out  1  stage 0 can accept a packet this cycle
- mult_cdb_req  out  1  penultimate stage holds a valid op
- mult_cdb_packet  out  CDB_REG_PACKET  valid, complete_tag, result

Behaviour:
- Stage register i holds: valid, func, dest tag, partial product (64b), multiplicand (64b), multiplier (64b).
- Stage 0 sign- or zero-extends operands to 64b by func:
  - MUL, MULH: both signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both unsigned.
- Final stage (NUM_STAGES-1) is the broadcast register.
- Advance rules:
  - The penultimate stage advances iff mult_cdb_gnt=1.
  - Stage i < NUM_STAGES-2 advances iff stage i+1 is empty or advancing (bubble compression).
  - The final stage empties every cycle.
- mult_free = !stage0.valid || stage0 advancing. This is combinational on mult_cdb_gnt, with no path from mult_packet.
- A mult_packet.valid arriving while mult_free=0 is a protocol error; the packet is dropped and state is unchanged.
- mult_cdb_req = penultimate.valid (combinational from registers).
- mult_cdb_packet.valid = final.valid.
  - result = product[31:0] for MUL, product[63:32] otherwise.
  - complete_tag = the op's dest tag.
  - When final.valid=0, all fields are 0.
- Latency: packet sampled at edge t, result visible on mult_cdb_packet during cycle t+NUM_STAGES-1 when no stall occurs. Throughput is 1 op/cycle.
- For NUM_STAGES=2 the penultimate stage is stage 0, and its valid bit drives mult_cdb_req.
- Ordering: results leave in issue order. There is no reordering.
- squash:
  - All stage valid bits except the final stage clear at the next edge.
  - The mult_packet in the same cycle is ignored.
  - A grant received during the squash cycle is consumed, with no broadcast.
  - The final-stage broadcast visible in the squash cycle still completes.
- Reset (async, active-low): all valid bits 0 immediately; mult_free=1; mult_cdb_req=0; mult_cdb_packet all zero. Reset mid-operation drops every in-flight op with no broadcast.
- Simultaneous events:
  - Issue and grant in the same cycle with a full pipe: accepted, because advance frees stage 0.
  - Squash and grant together: squash wins.

Optional Feature:
- Macro: MULT_FU_PERF_EN.
- Defined: adds outputs perf_issued (32b, ops accepted) and perf_stall (32b, cycles with mult_cdb_req=1 and mult_cdb_gnt=0). Both counters saturate at all-ones and clear on reset.
- Undefined: neither the ports nor the counters exist, and the datapath is identical.

Decomposition:
- sys_defs.svh holds MULT_PACKET, CDB_REG_PACKET, the MULT_FUNC enum, DATA, PHYS_REG_IDX and NUM_FU_MULT.
- Sub-module mult_stage: one combinational partial-product step of 64/NUM_STAGES multiplier bits, plus operand shift. Instantiated NUM_STAGES times.
- mult_fu_pipe owns the valid/advance/stall control.

Test Plan:
- Reset, then MUL 7×6 tag 12 at cycle 0 with mult_cdb_gnt=1 on req -> cdb valid at cycle 3 (NUM_STAGES=4), result 42, complete_tag 12.
- Signedness, one op per func, each broadcast in issue order:
  - MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000.
  - MULHU same operands -> 0xFFFFFFFE.
  - MULHSU same operands -> 0xFFFFFFFF.
- Stall: 5 back-to-back issues, grant held low 3 cycles after first req -> mult_free falls to 0 when the pipe is full; mult_cdb_req stays 1; all 5 results later appear in order with no loss or duplication; perf_stall=3 if enabled.
- Bubble compression: issue ops at cycles 0 and 2, gnt low cycles 2-4 -> op1 closes the gap behind op0; mult_free stays 1 until 3 stages are occupied.
- Squash with 3 ops in flight and 1 in the final stage -> the final-stage op broadcasts, the other 3 never appear, and mult_free=1 next cycle.
- Assert reset mid-stream with 2 ops in flight -> outputs zero immediately; after release there is no broadcast of the old ops, and a new MUL 3×3 returns 9.

Source files
------------

// File: rtl/mult_fu_pipe_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : mult_fu_pipe_pkg                                                   |
// | Brief  : Shared types for the pipelined multiply functional unit: the       |
// |          issue packet, the CDB packet, the RV32M multiply function enum,    |
// |          the per-stage pipeline register and an operand-extension helper.   |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
package mult_fu_pipe_pkg;

   localparam int XLEN        = 32;
   localparam int PHYS_REG_W  = 6;    // 64 physical registers
   localparam int NUM_FU_MULT = 1;

   typedef logic [XLEN-1:0]       DATA;
   typedef logic [PHYS_REG_W-1:0] PHYS_REG_IDX;

   typedef enum logic [1:0] {
      MUL    = 2'h0,
      MULH   = 2'h1,
      MULHSU = 2'h2,
      MULHU  = 2'h3
   } MULT_FUNC;

   typedef struct packed {
      logic        valid;
      MULT_FUNC    func;
      DATA         rs1_value;
      DATA         rs2_value;
      PHYS_REG_IDX dest_reg_idx;
   } MULT_PACKET;

   typedef struct packed {
      logic        valid;
      PHYS_REG_IDX complete_tag;
      DATA         result;
   } CDB_REG_PACKET;

   // One pipeline register: control plus the running shift-add state.
   typedef struct packed {
      logic        valid;
      MULT_FUNC    func;
      PHYS_REG_IDX tag;
      logic [63:0] product;
      logic [63:0] mcand;
      logic [63:0] mplier;
   } MULT_STAGE_REG;

   // Widen a 32-bit operand to 64 bits. With both operands widened to 64
   // bits, a truncated 64x64 unsigned product equals the exact product for
   // every signedness combination.
   function automatic logic [63:0] extend_operand(input DATA v, input logic is_signed);
      return {{32{is_signed & v[31]}}, v};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mult_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : mult_stage                                                         |
// | Brief  : One combinational shift-add step. Consumes BITS low multiplier     |
// |          bits, adds multiplicand*digit to the partial product, then shifts  |
// |          the multiplicand left and the multiplier right by BITS.            |
// | Ports  : product_in/mcand_in/mplier_in   running state in (64b each)        |
// |          product_out/mcand_out/mplier_out running state out (64b each)      |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module mult_stage #(
   parameter int BITS = 16
) (
   input  logic [63:0] product_in,
   input  logic [63:0] mcand_in,
   input  logic [63:0] mplier_in,
   output logic [63:0] product_out,
   output logic [63:0] mcand_out,
   output logic [63:0] mplier_out
);

   logic [63:0] digit;

   assign digit       = {{(64-BITS){1'b0}}, mplier_in[BITS-1:0]};
   assign product_out = product_in + (mcand_in * digit);
   assign mcand_out   = mcand_in << BITS;
   assign mplier_out  = mplier_in >> BITS;

endmodule
`default_nettype wire

// File: rtl/mult_fu_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : mult_fu_pipe                                                       |
// | Brief  : Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) sitting      |
// |          after issue. NUM_STAGES stage registers; the penultimate stage     |
// |          requests the CDB, the final stage is the broadcast register.       |
// |          Stalls on withheld grant and compresses bubbles upstream.          |
// | Ports  : clock, reset (async active-low)                                    |
// |          mult_packet   in   issued op                                       |
// |          squash        in   flush all in-flight ops                         |
// |          mult_cdb_gnt  in   CDB grant (meaningful only while requesting)    |
// |          mult_free     out  stage 0 can accept this cycle                   |
// |          mult_cdb_req  out  penultimate stage holds a valid op              |
// |          mult_cdb_packet out broadcast (all zero when idle)                 |
// |          perf_issued/perf_stall out (only with MULT_FU_PERF_EN defined)     |
// | Config : MULT_FU_PERF_EN adds saturating issue/stall counters.              |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module mult_fu_pipe
   import mult_fu_pipe_pkg::*;
#(
   parameter int NUM_STAGES = 4   // legal: 2, 4, 8
) (
   input  logic          clock,
   input  logic          reset,
   input  MULT_PACKET    mult_packet,
   input  logic          squash,
   input  logic          mult_cdb_gnt,
   output logic          mult_free,
   output logic          mult_cdb_req,
   output CDB_REG_PACKET mult_cdb_packet
`ifdef MULT_FU_PERF_EN
   ,
   output logic [31:0]   perf_issued,
   output logic [31:0]   perf_stall
`endif
);

   localparam int STEP_BITS = 64 / NUM_STAGES;
   localparam int PEN       = NUM_STAGES - 2;   // stage that requests the CDB
   localparam int LAST      = NUM_STAGES - 1;   // broadcast register

   MULT_STAGE_REG stage_q [NUM_STAGES];
   MULT_STAGE_REG stage_d [NUM_STAGES];

   logic [63:0] w_prod_in   [NUM_STAGES];
   logic [63:0] w_mcand_in  [NUM_STAGES];
   logic [63:0] w_mplier_in [NUM_STAGES];
   logic [63:0] w_prod_out  [NUM_STAGES];
   logic [63:0] w_mcand_out [NUM_STAGES];
   logic [63:0] w_mplier_out[NUM_STAGES];

   logic [NUM_STAGES-1:0] adv;     // stage i hands its op to stage i+1 this edge
   logic                  accept;
   logic                  rs1_signed;
   logic                  rs2_signed;

   assign rs1_signed = (mult_packet.func != MULHU);
   assign rs2_signed = (mult_packet.func == MUL) || (mult_packet.func == MULH);

   // ---------------------------------------------------------------- datapath
   // Step 0 works on the freshly extended operands so the stage-0 register
   // already holds the first partial product; step i sits between registers
   // i-1 and i.
   for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      if (i == 0) begin : g_first
         assign w_prod_in[i]   = 64'd0;
         assign w_mcand_in[i]  = extend_operand(mult_packet.rs1_value, rs1_signed);
         assign w_mplier_in[i] = extend_operand(mult_packet.rs2_value, rs2_signed);
      end else begin : g_rest
         assign w_prod_in[i]   = stage_q[i-1].product;
         assign w_mcand_in[i]  = stage_q[i-1].mcand;
         assign w_mplier_in[i] = stage_q[i-1].mplier;
      end

      mult_stage #(
         .BITS        (STEP_BITS)
      ) u_step (
         .product_in  (w_prod_in[i]),
         .mcand_in    (w_mcand_in[i]),
         .mplier_in   (w_mplier_in[i]),
         .product_out (w_prod_out[i]),
         .mcand_out   (w_mcand_out[i]),
         .mplier_out  (w_mplier_out[i])
      );
   end

   // ----------------------------------------------------------------- control
   always_comb begin
      adv       = '0;
      adv[LAST] = 1'b1;
      adv[PEN]  = stage_q[PEN].valid & mult_cdb_gnt;
      // Evaluated back-to-front so an advancing stage frees the one behind it
      // in the same cycle (bubble compression).
      for (int i = PEN - 1; i >= 0; i--) begin
         adv[i] = stage_q[i].valid & (!stage_q[i+1].valid | adv[i+1]);
      end

      mult_free    = !stage_q[0].valid | adv[0];
      mult_cdb_req = stage_q[PEN].valid;
      accept       = mult_packet.valid & mult_free & !squash;
   end

   always_comb begin
      for (int i = 0; i < NUM_STAGES; i++) begin
         stage_d[i] = stage_q[i];
      end

      if (accept) begin
         stage_d[0].valid   = 1'b1;
         stage_d[0].func    = mult_packet.func;
         stage_d[0].tag     = mult_packet.dest_reg_idx;
         stage_d[0].product = w_prod_out[0];
         stage_d[0].mcand   = w_mcand_out[0];
         stage_d[0].mplier  = w_mplier_out[0];
      end else if (adv[0]) begin
         stage_d[0].valid   = 1'b0;
      end

      for (int i = 1; i < NUM_STAGES; i++) begin
         if (adv[i-1]) begin
            stage_d[i].valid   = 1'b1;
            stage_d[i].func    = stage_q[i-1].func;
            stage_d[i].tag     = stage_q[i-1].tag;
            stage_d[i].product = w_prod_out[i];
            stage_d[i].mcand   = w_mcand_out[i];
            stage_d[i].mplier  = w_mplier_out[i];
         end else if (adv[i]) begin
            stage_d[i].valid   = 1'b0;
         end
      end

      // Squash kills everything still in flight, including an op that would
      // have entered the broadcast register on a grant this cycle.
      if (squash) begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            stage_d[i].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   // ------------------------------------------------------------------ output
   always_comb begin
      mult_cdb_packet = '0;
      if (stage_q[LAST].valid) begin
         mult_cdb_packet.valid        = 1'b1;
         mult_cdb_packet.complete_tag = stage_q[LAST].tag;
         mult_cdb_packet.result       = (stage_q[LAST].func == MUL) ?
                                        stage_q[LAST].product[31:0] :
                                        stage_q[LAST].product[63:32];
      end
   end

`ifdef MULT_FU_PERF_EN
   // ------------------------------------------------------------ perf counters
   logic [31:0] perf_issued_q, perf_issued_d;
   logic [31:0] perf_stall_q,  perf_stall_d;

   always_comb begin
      perf_issued_d = perf_issued_q;
      perf_stall_d  = perf_stall_q;
      if (accept && (perf_issued_q != '1)) begin
         perf_issued_d = perf_issued_q + 32'd1;
      end
      if (mult_cdb_req && !mult_cdb_gnt && (perf_stall_q != '1)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_issued_q <= perf_issued_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_issued = perf_issued_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire
